branch_resolve_queue: RTL and testbench

//  In-order queue of in-flight branches between fetch and execute. Captures the 2-bit

---
 rtl/branch_resolve_queue.sv | 134 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branches between fetch and execute.
// Emits predictor updates on resolution and a fetch redirect plus flush on a mispredict.
module branch_resolve_queue #(
  parameter int unsigned W_BRID = 2,
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned W_PTR  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_v_i,
  input  logic              push_pred_i,
  input  logic [W_BRID-1:0] push_pred_id_i,
  input  logic [W_ADDR-1:0] push_fallthru_i,
  input  logic [W_ADDR-1:0] push_target_i,
  output logic              full_o,
  input  logic              res_v_i,
  input  logic              res_taken_i,
  output logic              upd_v_o,
  output logic              upd_branch_o,
  output logic [W_BRID-1:0] upd_branch_id_o,
  output logic              redirect_o,
  output logic [W_ADDR-1:0] redirect_pc_o,
  output logic [W_PTR:0]    count_o,
  output logic              err_o
);

  localparam int unsigned W_CNT = W_PTR + 1;

  logic              pred_mem [DEPTH];
  logic [W_BRID-1:0] id_mem   [DEPTH];
  logic [W_ADDR-1:0] ft_mem   [DEPTH];
  logic [W_ADDR-1:0] tgt_mem  [DEPTH];

  logic [W_PTR-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              upd_v_q, upd_v_d;
  logic              upd_br_q, upd_br_d;
  logic [W_BRID-1:0] upd_id_q, upd_id_d;
  logic              redir_q, redir_d;
  logic [W_ADDR-1:0] rpc_q, rpc_d;

  logic              pop, mispred, wr_en;

  // A mispredict squashes any same-cycle push: it is on the wrong path.
  always_comb begin
    pop     = res_v_i & (cnt_q != '0);
    mispred = pop & (pred_mem[rd_q] != res_taken_i);
    wr_en   = push_v_i & ~full_q & ~mispred;
  end

  always_comb begin
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    upd_v_d  = 1'b0;
    upd_br_d = upd_br_q;
    upd_id_d = upd_id_q;
    redir_d  = 1'b0;
    rpc_d    = rpc_q;

    if (wr_en) wr_d = wr_q + W_PTR'(1);

    if (mispred) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else begin
      if (pop) rd_d = rd_q + W_PTR'(1);
      cnt_d = cnt_q + W_CNT'(wr_en) - W_CNT'(pop);
    end
    full_d = (cnt_d == W_CNT'(DEPTH));

    if (pop) begin
      upd_v_d  = 1'b1;
      upd_br_d = res_taken_i;
      upd_id_d = id_mem[rd_q];
    end
    if (mispred) begin
      redir_d = 1'b1;
      rpc_d   = res_taken_i ? tgt_mem[rd_q] : ft_mem[rd_q];
    end

    if ((push_v_i & full_q & ~mispred) | (res_v_i & ~pop)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      upd_v_q  <= 1'b0;
      upd_br_q <= 1'b0;
      upd_id_q <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      err_q    <= err_d;
      upd_v_q  <= upd_v_d;
      upd_br_q <= upd_br_d;
      upd_id_q <= upd_id_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pred_mem[wr_q] <= push_pred_i;
      id_mem[wr_q]   <= push_pred_id_i;
      ft_mem[wr_q]   <= push_fallthru_i;
      tgt_mem[wr_q]  <= push_target_i;
    end
  end

  assign full_o          = full_q;
  assign count_o         = cnt_q;
  assign err_o           = err_q;
  assign upd_v_o         = upd_v_q;
  assign upd_branch_o    = upd_br_q;
  assign upd_branch_id_o = upd_id_q;
  assign redirect_o      = redir_q;
  assign redirect_pc_o   = rpc_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_v_i, push_pred_i, res_v_i, res_taken_i;
  logic [1:0]  push_pred_id_i;
  logic [31:0] push_fallthru_i, push_target_i;
  logic        full_o, upd_v_o, upd_branch_o, redirect_o, err_o;
  logic [1:0]  upd_branch_id_o;
  logic [31:0] redirect_pc_o;
  logic [2:0]  count_o;

  branch_resolve_queue dut (
    .clk(clk), .reset(reset),
    .push_v_i(push_v_i), .push_pred_i(push_pred_i), .push_pred_id_i(push_pred_id_i),
    .push_fallthru_i(push_fallthru_i), .push_target_i(push_target_i),
    .full_o(full_o), .res_v_i(res_v_i), .res_taken_i(res_taken_i),
    .upd_v_o(upd_v_o), .upd_branch_o(upd_branch_o), .upd_branch_id_o(upd_branch_id_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic [1:0]  id;
    logic [31:0] ft;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic        e_upd_v, e_br, e_redir, e_err;
  logic [1:0]  e_id;
  logic [31:0] e_pc;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    e_upd_v = 0; e_br = 0; e_id = 0; e_redir = 0; e_pc = 0; e_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_upd_v", 32'(upd_v_o), 32'd0);
    check("rst_redir", 32'(redirect_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive at negedge, advance the model, check just after posedge.
  task automatic step(input logic push, input logic pred, input logic [1:0] id,
                      input logic [31:0] ft, input logic [31:0] tgt,
                      input logic res, input logic taken);
    ent_t h;
    bit   was_full, misp;
    @(negedge clk);
    push_v_i = push; push_pred_i = pred; push_pred_id_i = id;
    push_fallthru_i = ft; push_target_i = tgt;
    res_v_i = res; res_taken_i = taken;

    was_full = (q.size() == DEPTH);
    misp = 0;
    e_upd_v = 0; e_redir = 0;
    if (res && q.size() != 0) begin
      h = q.pop_front();
      e_upd_v = 1; e_br = taken; e_id = h.id;
      if (h.pred != taken) begin
        misp = 1; e_redir = 1;
        e_pc = taken ? h.tgt : h.ft;
        q.delete();
      end
    end else if (res) begin
      e_err = 1;
    end
    if (push && !misp) begin
      if (was_full) e_err = 1;
      else q.push_back('{pred, id, ft, tgt});
    end

    @(posedge clk);
    #1;
    check("count", 32'(count_o), 32'(q.size()));
    check("full", 32'(full_o), 32'(q.size() == DEPTH));
    check("upd_v", 32'(upd_v_o), 32'(e_upd_v));
    check("redirect", 32'(redirect_o), 32'(e_redir));
    check("redirect_pc", redirect_pc_o, e_pc);
    check("err", 32'(err_o), 32'(e_err));
    if (e_upd_v) begin
      check("upd_branch", 32'(upd_branch_o), 32'(e_br));
      check("upd_id", 32'(upd_branch_id_o), 32'(e_id));
    end
    push_v_i = 0; res_v_i = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Push a branch and resolve the head as predicted in the same cycle.
  task automatic push_and_resolve_ok(input logic [1:0] id);
    logic hp;
    hp = (q.size() != 0) ? q[0].pred : 1'b0;
    step(1, id[0], id, 32'h1000 + 32'(id), 32'h2000 + 32'(id), 1, hp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rid;
    logic       p, r, t, rp;
    reset = 1'b0;
    push_v_i = 0; push_pred_i = 0; push_pred_id_i = 0;
    push_fallthru_i = 0; push_target_i = 0; res_v_i = 0; res_taken_i = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Correct taken prediction
    step(1, 1, 2'b10, 32'h24, 32'h100, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check("taken_upd_v", 32'(upd_v_o), 32'd1);
    check("taken_upd_id", 32'(upd_branch_id_o), 32'd2);
    check("taken_redir", 32'(redirect_o), 32'd0);
    idle();

    // Mispredict flush with a wrong-path push in the same cycle
    do_reset();
    step(1, 0, 2'b01, 32'h44, 32'h200, 0, 0);
    step(1, 1, 2'b11, 32'h48, 32'h300, 0, 0);
    step(1, 0, 2'b00, 32'h4c, 32'h400, 0, 0);
    step(1, 1, 2'b10, 32'h50, 32'h500, 1, 1);
    check("misp_pc", redirect_pc_o, 32'h200);
    check("misp_count", 32'(count_o), 32'd0);
    check("misp_err", 32'(err_o), 32'd0);
    idle();
    check("redir_pulse", 32'(redirect_o), 32'd0);

    // Full, overflow drop, then wrap-around ordering
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 2'(i), 32'(i), 32'(i + 16), 0, 0);
    check("full_set", 32'(full_o), 32'd1);
    step(1, 0, 2'b11, 32'h99, 32'h98, 0, 0);
    check("ovf_err", 32'(err_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 1, 1);
      step(1, 1, 2'(i + 1), 32'(i), 32'(i), 0, 0);
    end

    // Resolve on an empty queue
    do_reset();
    step(0, 0, 0, 0, 0, 1, 1);
    check("empty_upd_v", 32'(upd_v_o), 32'd0);
    idle();
    check("empty_err_sticky", 32'(err_o), 32'd1);

    // Simultaneous push and correct resolve, back-to-back
    do_reset();
    step(1, 0, 2'b00, 32'h10, 32'h20, 0, 0);
    step(1, 1, 2'b01, 32'h14, 32'h24, 0, 0);
    for (int i = 0; i < 5; i++) push_and_resolve_ok(2'(i + 2));
    check("simul_count", 32'(count_o), 32'd2);
    idle();

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p   = ($urandom_range(0, 99) < 55);
      r   = ($urandom_range(0, 99) < 45);
      rid = 2'($urandom);
      rp  = 1'($urandom);
      if (q.size() != 0 && $urandom_range(0, 3) != 0) t = q[0].pred;
      else t = 1'($urandom);
      step(p, rp, rid, $urandom, $urandom, r, t);
      if (i == 200) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
